load_ctrl: RTL and testbench

Multicycle sequencer for the load path of the CPU: issues the memory read, waits the fixed memory latency, strobes the MDR, then drives the load-size unit's `loadSel`/`exceptionControl` selects and the final register-file or PC write. It serves both `lb`/`lh`/`lw` loads and exception-vector fetches, where the handler address is the top byte of the word read from 253/254/255. It sits between the main control FSM and the memory/MDR/load-size datapath.

---
 rtl/load_ctrl.sv | 129 ++++++++++++
 tb/tb_load_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_ctrl.sv
// Load-path sequencer: issues the memory read, waits out the memory latency, strobes the MDR,
// then drives the load-size selects and the final register-file or PC write.
module load_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [1:0]  exc_req,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mdr_we,
  output logic [1:0]  load_sel,
  output logic [1:0]  exception_control,
  output logic        rf_we,
  output logic        pc_we,
  output logic        epc_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_WB
  } state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_isExc;
  logic [1:0]  r_size;
  logic [1:0]  r_code;
  logic [31:0] r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latches; an exception outranks a simultaneous start, which is simply dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_isExc <= 1'b0;
      r_size  <= 2'b10;
      r_code  <= 2'b00;
      r_addr  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exc_req != 2'b00) begin
            r_isExc <= 1'b1;
            r_code  <= exc_req;
            r_size  <= 2'b10;
            r_addr  <= {30'd0, exc_req} + 32'd252;
          end else if (start) begin
            r_isExc <= 1'b0;
            r_code  <= 2'b00;
            r_size  <= (size == 2'b11) ? 2'b10 : size;
            r_addr  <= addr;
          end
        end
        S_ISSUE: r_cnt <= LP_CNT_INIT;
        S_WAIT:  r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next            = r_state;
    mem_rd            = 1'b0;
    mdr_we            = 1'b0;
    rf_we             = 1'b0;
    pc_we             = 1'b0;
    epc_we            = 1'b0;
    done              = 1'b0;
    busy              = 1'b1;
    load_sel          = r_size;
    exception_control = r_code;
    case (r_state)
      S_IDLE: begin
        busy              = 1'b0;
        load_sel          = 2'b10;
        exception_control = 2'b00;
        if ((exc_req != 2'b00) || start) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_rd = 1'b1;
        epc_we = r_isExc;
        w_next = (MEM_LAT == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        // Counter was loaded with MEM_LAT-1, so leaving at 1 gives MEM_LAT-1 wait cycles.
        if (r_cnt <= 4'd1) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        mdr_we = 1'b1;
        w_next = S_WB;
      end
      S_WB: begin
        done   = 1'b1;
        rf_we  = ~r_isExc;
        pc_we  = r_isExc;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr = r_addr;

endmodule

// File: tb/tb_load_ctrl.sv
// Scoreboard bench for load_ctrl: one instance at MEM_LAT=2 and one at MEM_LAT=1, driven one at a time.
module tb_load_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic [1:0]  start;
  logic [1:0]  size   [2];
  logic [31:0] addr   [2];
  logic [1:0]  excReq [2];

  wire [31:0] memAddr [2];
  wire [1:0]  loadSel [2];
  wire [1:0]  excCtrl [2];
  wire [1:0]  memRd, mdrWe, rfWe, pcWe, epcWe, busy, done;

  int cycleCnt   = 0;
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          dut;
    logic        isExc;
    logic [31:0] addr;
    logic [1:0]  lsel;
    logic [1:0]  ectl;
    int          issueEdge;
  } expT;

  expT expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  load_ctrl #(.MEM_LAT(2)) u0 (
    .clk(clk), .reset_n(resetN), .start(start[0]), .size(size[0]), .addr(addr[0]),
    .exc_req(excReq[0]), .mem_addr(memAddr[0]), .mem_rd(memRd[0]), .mdr_we(mdrWe[0]),
    .load_sel(loadSel[0]), .exception_control(excCtrl[0]), .rf_we(rfWe[0]), .pc_we(pcWe[0]),
    .epc_we(epcWe[0]), .busy(busy[0]), .done(done[0])
  );

  load_ctrl #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset_n(resetN), .start(start[1]), .size(size[1]), .addr(addr[1]),
    .exc_req(excReq[1]), .mem_addr(memAddr[1]), .mem_rd(memRd[1]), .mdr_we(mdrWe[1]),
    .load_sel(loadSel[1]), .exception_control(excCtrl[1]), .rf_we(rfWe[1]), .pc_we(pcWe[1]),
    .epc_we(epcWe[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Monitor: each strobe the DUT raises is matched against the oldest outstanding request.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  lat;
      expT e;
      lat = (d == 0) ? 2 : 1;
      if (memRd[d] || mdrWe[d] || done[d] || rfWe[d] || pcWe[d] || epcWe[d]) begin
        if (expQ.size() == 0 || expQ[0].dut != d) begin
          checkOutput($sformatf("unexpectedStrobe%0d", d),
                      {26'd0, memRd[d], mdrWe[d], done[d], rfWe[d], pcWe[d], epcWe[d]}, 32'd0);
        end else begin
          e = expQ[0];
          if (memRd[d] || epcWe[d]) begin
            checkOutput("rdEdge",   32'(cycleCnt), 32'(e.issueEdge));
            checkOutput("rdStrobe", 32'(memRd[d]), 32'd1);
            checkOutput("rdAddr",   memAddr[d], e.addr);
            checkOutput("epcWe",    32'(epcWe[d]), 32'(e.isExc));
            checkOutput("rdLsel",   32'(loadSel[d]), 32'(e.lsel));
            checkOutput("rdEctl",   32'(excCtrl[d]), 32'(e.ectl));
            checkOutput("rdBusy",   32'(busy[d]), 32'd1);
          end
          if (mdrWe[d]) begin
            checkOutput("capEdge", 32'(cycleCnt), 32'(e.issueEdge + lat));
            checkOutput("capLsel", 32'(loadSel[d]), 32'(e.lsel));
            checkOutput("capEctl", 32'(excCtrl[d]), 32'(e.ectl));
          end
          if (done[d] || rfWe[d] || pcWe[d]) begin
            checkOutput("wbEdge", 32'(cycleCnt), 32'(e.issueEdge + lat + 1));
            checkOutput("wbDone", 32'(done[d]), 32'd1);
            checkOutput("rfWe",   32'(rfWe[d]), 32'(!e.isExc));
            checkOutput("pcWe",   32'(pcWe[d]), 32'(e.isExc));
            checkOutput("wbLsel", 32'(loadSel[d]), 32'(e.lsel));
            checkOutput("wbEctl", 32'(excCtrl[d]), 32'(e.ectl));
            checkOutput("wbAddr", memAddr[d], e.addr);
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // Drive one request into an idle DUT and queue its hand-computed response.
  task automatic applyStimulus(input int d, input logic st, input logic [1:0] sz,
                               input logic [31:0] ad, input logic [1:0] ex,
                               input logic expIsExc, input logic [31:0] expAddr,
                               input logic [1:0] expLsel, input logic [1:0] expEctl);
    expT e;
    start[d]    = st;
    size[d]     = sz;
    addr[d]     = ad;
    excReq[d]   = ex;
    e.dut       = d;
    e.isExc     = expIsExc;
    e.addr      = expAddr;
    e.lsel      = expLsel;
    e.ectl      = expEctl;
    e.issueEdge = cycleCnt + 1;
    expQ.push_back(e);
    @(negedge clk);
  endtask

  task automatic clearInputs(input int d);
    start[d]  = 1'b0;
    size[d]   = 2'b00;
    addr[d]   = 32'd0;
    excReq[d] = 2'b00;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  // Full request, then verify the IDLE cycle that follows WB.
  task automatic runOne(input int d, input logic st, input logic [1:0] sz,
                        input logic [31:0] ad, input logic [1:0] ex,
                        input logic expIsExc, input logic [31:0] expAddr,
                        input logic [1:0] expLsel, input logic [1:0] expEctl);
    applyStimulus(d, st, sz, ad, ex, expIsExc, expAddr, expLsel, expEctl);
    clearInputs(d);
    waitDone(20);
    @(negedge clk);
    #1;
    checkOutput("idleBusy", 32'(busy[d]), 32'd0);
    checkOutput("idleLsel", 32'(loadSel[d]), 32'h2);
    checkOutput("idleEctl", 32'(excCtrl[d]), 32'd0);
  endtask

  task automatic checkQuiet(input int d, input string tag);
    checkOutput({tag, "Busy"},    32'(busy[d]), 32'd0);
    checkOutput({tag, "Strobes"}, {26'd0, memRd[d], mdrWe[d], done[d], rfWe[d], pcWe[d], epcWe[d]}, 32'd0);
    checkOutput({tag, "Addr"},    memAddr[d], 32'd0);
    checkOutput({tag, "Lsel"},    32'(loadSel[d]), 32'h2);
    checkOutput({tag, "Ectl"},    32'(excCtrl[d]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetN = 1'b0;
    clearInputs(0);
    clearInputs(1);
    repeat (3) @(negedge clk);
    #1;
    checkQuiet(0, "rst0");
    checkQuiet(1, "rst1");
    resetN = 1'b1;
    @(negedge clk);
    #1;

    // Byte, half, word and size 11 loads issued back-to-back on the MEM_LAT=2 instance.
    runOne(0, 1'b1, 2'b00, 32'h0000_0040, 2'b00, 1'b0, 32'h0000_0040, 2'b00, 2'b00);
    runOne(0, 1'b1, 2'b01, 32'h0000_1002, 2'b00, 1'b0, 32'h0000_1002, 2'b01, 2'b00);
    runOne(0, 1'b1, 2'b11, 32'h0000_2000, 2'b00, 1'b0, 32'h0000_2000, 2'b10, 2'b00);
    runOne(0, 1'b1, 2'b10, 32'h0000_3004, 2'b00, 1'b0, 32'h0000_3004, 2'b10, 2'b00);

    // Overflow exception beats a simultaneous start; start stays held and is taken afterwards.
    applyStimulus(0, 1'b1, 2'b00, 32'h0000_0080, 2'b10, 1'b1, 32'd254, 2'b10, 2'b10);
    excReq[0] = 2'b00;
    waitDone(20);
    @(negedge clk);
    #1;
    applyStimulus(0, 1'b1, 2'b00, 32'h0000_0080, 2'b00, 1'b0, 32'h0000_0080, 2'b00, 2'b00);
    clearInputs(0);
    waitDone(20);
    @(negedge clk);
    #1;

    // MEM_LAT=1 instance: exception vectors 253 and 255, then a half load.
    runOne(1, 1'b0, 2'b00, 32'd0, 2'b01, 1'b1, 32'd253, 2'b10, 2'b01);
    runOne(1, 1'b0, 2'b00, 32'd0, 2'b11, 1'b1, 32'd255, 2'b10, 2'b11);
    runOne(1, 1'b1, 2'b01, 32'h0000_000C, 2'b00, 1'b0, 32'h0000_000C, 2'b01, 2'b00);

    // start held through cycles 1..3 of an active load must not spawn a second read.
    applyStimulus(0, 1'b1, 2'b01, 32'h0000_0500, 2'b00, 1'b0, 32'h0000_0500, 2'b01, 2'b00);
    start[0] = 1'b1;
    size[0]  = 2'b10;
    addr[0]  = 32'h0000_0600;
    repeat (3) @(negedge clk);
    #1;
    clearInputs(0);
    waitDone(20);
    @(negedge clk);
    #1;
    runOne(0, 1'b1, 2'b10, 32'h0000_0700, 2'b00, 1'b0, 32'h0000_0700, 2'b10, 2'b00);

    // Reset during WAIT abandons the load with no write.
    applyStimulus(0, 1'b1, 2'b00, 32'h0000_0900, 2'b00, 1'b0, 32'h0000_0900, 2'b00, 2'b00);
    clearInputs(0);
    @(negedge clk);
    #1;
    checkOutput("preRstBusy", 32'(busy[0]), 32'd1);
    resetN = 1'b0;
    #1;
    checkQuiet(0, "midRst");
    expQ.delete();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    #1;
    runOne(0, 1'b1, 2'b01, 32'h0000_0A00, 2'b00, 1'b0, 32'h0000_0A00, 2'b01, 2'b00);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
